// File: rtl/fall_slot_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fall_slot_scheduler_if                                                     |
// | Spawn handshake, key input and renderer read port of the slot scheduler.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fall_slot_scheduler_if #(
  parameter int SLOTS   = 16,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int SPEED_W = 4
);
  localparam int IW = $clog2(SLOTS);

  logic               spawn_valid;
  logic               spawn_ready;
  logic [7:0]         spawn_ch;
  logic [X_W-1:0]     spawn_x;
  logic [SPEED_W-1:0] spawn_speed;
  logic               key_valid;
  logic [7:0]         key_ascii;
  logic [IW-1:0]      rd_slot;
  logic               rd_active;
  logic [7:0]         rd_ch;
  logic [X_W-1:0]     rd_x;
  logic [Y_W-1:0]     rd_y;

  modport master (
    output spawn_valid, spawn_ch, spawn_x, spawn_speed, key_valid, key_ascii, rd_slot,
    input  spawn_ready, rd_active, rd_ch, rd_x, rd_y
  );

  modport slave (
    input  spawn_valid, spawn_ch, spawn_x, spawn_speed, key_valid, key_ascii, rd_slot,
    output spawn_ready, rd_active, rd_ch, rd_x, rd_y
  );
endinterface
`default_nettype wire

// File: rtl/fall_slot_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fall_slot_scheduler                                                        |
// | Table of falling characters: spawn, per-frame move/retire, key hit clear. |
// | Optional macro SCORE_PENALTY_EN: unmatched key pulses wrong and costs 1.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fall_slot_scheduler #(
  parameter int SLOTS   = 16,
  parameter int Y_MAX   = 464,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int SPEED_W = 4
) (
  input  wire                     clk,
  input  wire                     rst,
  input  wire                     i_frame_tick,
  fall_slot_scheduler_if.slave    bus,
  output logic                    o_hit_pulse,
  output logic                    o_miss_pulse,
  output logic                    o_wrong_pulse,
  output logic [15:0]             o_score,
  output logic [7:0]              o_miss_count,
  output logic [$clog2(SLOTS):0]  o_active_count,
  output logic                    o_busy
);
  localparam int IW = $clog2(SLOTS);
  localparam logic [IW:0]  c_last_slot = (IW+1)'(SLOTS - 1);
  localparam logic [IW:0]  c_resolve   = (IW+1)'(SLOTS);
  localparam logic [Y_W:0] c_y_max     = (Y_W+1)'(Y_MAX);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_KEY = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  logic               r_act [SLOTS];
  logic [7:0]         r_ch  [SLOTS];
  logic [X_W-1:0]     r_x   [SLOTS];
  logic [Y_W-1:0]     r_y   [SLOTS];
  logic [SPEED_W-1:0] r_spd [SLOTS];

  logic           r_tick_pend, r_key_pend;
  logic [7:0]     r_key_ascii, r_key_cur;
  logic [IW:0]    r_idx;
  logic           r_cand_vld;
  logic [IW-1:0]  r_cand_idx;
  logic [Y_W-1:0] r_cand_y;
  logic           r_rd_active;
  logic [7:0]     r_rd_ch;
  logic [X_W-1:0] r_rd_x;
  logic [Y_W-1:0] r_rd_y;

  logic           w_any_free, w_spawn, w_take_tick, w_take_key, w_miss, w_resolve, w_match;
  logic [IW-1:0]  w_free_idx, w_slot;
  logic [Y_W:0]   w_y_new;

  // Downward scan leaves the lowest-index free slot in w_free_idx.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!r_act[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_slot          = r_idx[IW-1:0];
    w_y_new         = {1'b0, r_y[w_slot]} + {{(Y_W+1-SPEED_W){1'b0}}, r_spd[w_slot]};
    w_take_tick     = (r_state == ST_IDLE) && r_tick_pend;
    w_take_key      = (r_state == ST_IDLE) && !r_tick_pend && r_key_pend;
    bus.spawn_ready = !rst && (r_state == ST_IDLE) && !r_tick_pend && !r_key_pend && w_any_free;
    w_spawn         = bus.spawn_ready && bus.spawn_valid;
    w_miss          = (r_state == ST_MOVE) && r_act[w_slot] && (w_y_new >= c_y_max);
    w_resolve       = (r_state == ST_KEY) && (r_idx == c_resolve);
    w_match         = (r_state == ST_KEY) && !r_idx[IW] && r_act[w_slot] &&
                      (r_ch[w_slot] == r_key_cur) && (!r_cand_vld || (r_y[w_slot] > r_cand_y));
    o_miss_pulse    = !rst && w_miss;
    o_hit_pulse     = !rst && w_resolve && r_cand_vld;
`ifdef SCORE_PENALTY_EN
    o_wrong_pulse   = !rst && w_resolve && !r_cand_vld;
`else
    o_wrong_pulse   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_tick_pend)     w_state_nxt = ST_MOVE;
        else if (r_key_pend) w_state_nxt = ST_KEY;
      end
      ST_MOVE: if (r_idx == c_last_slot) w_state_nxt = ST_IDLE;
      ST_KEY:  if (r_idx == c_resolve)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_act[i] <= 1'b0;
        r_ch[i]  <= '0;
        r_x[i]   <= '0;
        r_y[i]   <= '0;
        r_spd[i] <= '0;
      end
      r_tick_pend    <= 1'b0;
      r_key_pend     <= 1'b0;
      r_key_ascii    <= '0;
      r_key_cur      <= '0;
      r_idx          <= '0;
      r_cand_vld     <= 1'b0;
      r_cand_idx     <= '0;
      r_cand_y       <= '0;
      r_rd_active    <= 1'b0;
      r_rd_ch        <= '0;
      r_rd_x         <= '0;
      r_rd_y         <= '0;
      o_score        <= '0;
      o_miss_count   <= '0;
      o_active_count <= '0;
    end else begin
      // A request arriving in its own consume cycle re-arms the flag.
      r_tick_pend <= i_frame_tick || (r_tick_pend && !w_take_tick);
      r_key_pend  <= bus.key_valid || (r_key_pend && !w_take_key);
      if (bus.key_valid) r_key_ascii <= bus.key_ascii;
      if (w_take_key)    r_key_cur   <= r_key_ascii;

      r_rd_active <= r_act[bus.rd_slot];
      r_rd_ch     <= r_ch[bus.rd_slot];
      r_rd_x      <= r_x[bus.rd_slot];
      r_rd_y      <= r_y[bus.rd_slot];

      case (r_state)
        ST_IDLE: begin
          r_idx      <= '0;
          r_cand_vld <= 1'b0;
          if (w_spawn) begin
            r_act[w_free_idx] <= 1'b1;
            r_ch[w_free_idx]  <= bus.spawn_ch;
            r_x[w_free_idx]   <= bus.spawn_x;
            r_y[w_free_idx]   <= '0;
            r_spd[w_free_idx] <= bus.spawn_speed;
            o_active_count    <= o_active_count + 1'b1;
          end
        end
        ST_MOVE: begin
          r_idx <= r_idx + 1'b1;
          if (w_miss) begin
            r_act[w_slot]  <= 1'b0;
            o_active_count <= o_active_count - 1'b1;
            if (o_miss_count != 8'hFF) o_miss_count <= o_miss_count + 1'b1;
          end else if (r_act[w_slot]) begin
            r_y[w_slot] <= w_y_new[Y_W-1:0];
          end
        end
        ST_KEY: begin
          r_idx <= r_idx + 1'b1;
          if (w_match) begin
            r_cand_vld <= 1'b1;
            r_cand_idx <= w_slot;
            r_cand_y   <= r_y[w_slot];
          end
          if (w_resolve && r_cand_vld) begin
            r_act[r_cand_idx] <= 1'b0;
            o_active_count    <= o_active_count - 1'b1;
            if (o_score != 16'hFFFF) o_score <= o_score + 1'b1;
          end
`ifdef SCORE_PENALTY_EN
          if (w_resolve && !r_cand_vld && (o_score != 16'h0000)) o_score <= o_score - 1'b1;
`endif
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign bus.rd_active = r_rd_active;
  assign bus.rd_ch     = r_rd_ch;
  assign bus.rd_x      = r_rd_x;
  assign bus.rd_y      = r_rd_y;
  assign o_busy        = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_fall_slot_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fall_slot_scheduler                                                     |
// | Directed bench for fall_slot_scheduler with SLOTS=16.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fall_slot_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic hit_pulse, miss_pulse, wrong_pulse, busy;
  logic [15:0] score;
  logic [7:0]  miss_count;
  logic [4:0]  active_count;
  int checks = 0;
  int errors = 0;
  int m, h, w, b, tot, n;

  always #5 clk = ~clk;

  fall_slot_scheduler_if #(.SLOTS(16), .X_W(10), .Y_W(9), .SPEED_W(4)) bus ();

  fall_slot_scheduler #(.SLOTS(16), .Y_MAX(464), .X_W(10), .Y_W(9), .SPEED_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_frame_tick   (frame_tick),
    .bus            (bus),
    .o_hit_pulse    (hit_pulse),
    .o_miss_pulse   (miss_pulse),
    .o_wrong_pulse  (wrong_pulse),
    .o_score        (score),
    .o_miss_count   (miss_count),
    .o_active_count (active_count),
    .o_busy         (busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic spawn(input logic [7:0] ch, input logic [9:0] x, input logic [3:0] sp);
    bus.spawn_valid = 1'b1;
    bus.spawn_ch    = ch;
    bus.spawn_x     = x;
    bus.spawn_speed = sp;
    check("spawn_ready", {31'd0, bus.spawn_ready}, 32'd1);
    cyc();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] slot);
    bus.rd_slot = slot;
    cyc();
  endtask

  task automatic frame(output int misses);
    int k;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    misses = 0;
    k = 0;
    while (busy && k < 100) begin
      if (miss_pulse) misses++;
      cyc();
      k++;
    end
    if (k >= 100) begin
      errors++;
      $error("FAIL frame_timeout observed %0d expected <100", k);
    end
  endtask

  // Window of 60 cycles after the pulse; counts busy and pulse cycles.
  task automatic watch(output int hits, output int wrongs, output int busyc, output int misses);
    hits = 0; wrongs = 0; busyc = 0; misses = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy)        busyc++;
      if (hit_pulse)   hits++;
      if (wrong_pulse) wrongs++;
      if (miss_pulse)  misses++;
      cyc();
    end
  endtask

  task automatic key(input logic [7:0] k, output int hits, output int wrongs, output int busyc);
    int mm;
    bus.key_ascii = k;
    bus.key_valid = 1'b1;
    cyc();
    bus.key_valid = 1'b0;
    watch(hits, wrongs, busyc, mm);
  endtask

  initial begin
    bus.spawn_valid = 1'b0;
    bus.spawn_ch    = '0;
    bus.spawn_x     = '0;
    bus.spawn_speed = '0;
    bus.key_valid   = 1'b0;
    bus.key_ascii   = '0;
    bus.rd_slot     = '0;
    cyc(); cyc(); cyc();
    check("rst_ready", {31'd0, bus.spawn_ready}, 32'd0);
    check("rst_active_count", {27'd0, active_count}, 32'd0);
    check("rst_score", {16'd0, score}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cyc();

    // First spawn lands in slot 0 at y=0
    spawn(8'h41, 10'd100, 4'd3);
    check("spawn_active_count", {27'd0, active_count}, 32'd1);
    rd(4'd0);
    check("rd_active_A", {31'd0, bus.rd_active}, 32'd1);
    check("rd_ch_A", {24'd0, bus.rd_ch}, 32'h41);
    check("rd_x_A", {22'd0, bus.rd_x}, 32'd100);
    check("rd_y_A", {23'd0, bus.rd_y}, 32'd0);

    // 154 frames bring y to 462; the 155th retires it
    tot = 0;
    for (int i = 0; i < 154; i++) begin
      frame(m);
      tot += m;
    end
    check("no_early_miss", tot, 32'd0);
    rd(4'd0);
    check("rd_y_462", {23'd0, bus.rd_y}, 32'd462);
    frame(m);
    check("miss_pulses", m, 32'd1);
    check("miss_count", {24'd0, miss_count}, 32'd1);
    check("retire_active_count", {27'd0, active_count}, 32'd0);
    rd(4'd0);
    check("retired_inactive", {31'd0, bus.rd_active}, 32'd0);

    // B at y=30 (slot 0) and B at y=90 (slot 1); key B clears the lower one
    spawn(8'h42, 10'd10, 4'd3);
    spawn(8'h42, 10'd20, 4'd9);
    for (int i = 0; i < 10; i++) frame(m);
    key(8'h42, h, w, b);
    check("hitB_pulses", h, 32'd1);
    check("hitB_busy", b, 32'd17);
    check("hitB_score", {16'd0, score}, 32'd1);
    check("hitB_active_count", {27'd0, active_count}, 32'd1);
    rd(4'd1);
    check("hitB_slot1_cleared", {31'd0, bus.rd_active}, 32'd0);
    rd(4'd0);
    check("hitB_slot0_kept", {31'd0, bus.rd_active}, 32'd1);
    check("hitB_slot0_y", {23'd0, bus.rd_y}, 32'd30);

    // Fill the remaining 15 slots with stationary letters 'b'..'p'
    for (int i = 1; i < 16; i++) spawn(8'h61 + 8'(i), 10'(i * 10), 4'd0);
    check("full_active_count", {27'd0, active_count}, 32'd16);
    bus.spawn_valid = 1'b1;
    bus.spawn_ch    = 8'h51;
    bus.spawn_x     = 10'd7;
    bus.spawn_speed = 4'd0;
    cyc();
    check("full_ready_0", {31'd0, bus.spawn_ready}, 32'd0);
    bus.key_ascii = 8'h65;
    bus.key_valid = 1'b1;
    cyc();
    bus.key_valid = 1'b0;
    check("full_ready_1", {31'd0, bus.spawn_ready}, 32'd0);
    h = 0;
    n = 0;
    while (!bus.spawn_ready && n < 50) begin
      if (hit_pulse) h++;
      cyc();
      n++;
    end
    check("freed_ready", {31'd0, bus.spawn_ready}, 32'd1);
    check("freed_hits", h, 32'd1);
    cyc();
    bus.spawn_valid = 1'b0;
    check("refill_active_count", {27'd0, active_count}, 32'd16);
    check("refill_score", {16'd0, score}, 32'd2);
    rd(4'd4);
    check("refill_slot4_ch", {24'd0, bus.rd_ch}, 32'h51);
    check("refill_slot4_x", {22'd0, bus.rd_x}, 32'd7);

    // Tick and key together: MOVE then KEY
    bus.key_ascii = 8'h51;
    bus.key_valid = 1'b1;
    frame_tick    = 1'b1;
    cyc();
    bus.key_valid = 1'b0;
    frame_tick    = 1'b0;
    watch(h, w, b, m);
    check("both_busy", b, 32'd33);
    check("both_hits", h, 32'd1);
    check("both_misses", m, 32'd0);
    check("both_score", {16'd0, score}, 32'd3);
    check("both_active_count", {27'd0, active_count}, 32'd15);
    rd(4'd0);
    check("both_slot0_y", {23'd0, bus.rd_y}, 32'd33);
    rd(4'd4);
    check("both_slot4_cleared", {31'd0, bus.rd_active}, 32'd0);

    // Unmatched key
    key(8'h5A, h, w, b);
    check("wrong_hits", h, 32'd0);
    check("wrong_busy", b, 32'd17);
`ifdef SCORE_PENALTY_EN
    check("wrong_pulses", w, 32'd1);
    check("wrong_score", {16'd0, score}, 32'd2);
`else
    check("wrong_pulses", w, 32'd0);
    check("wrong_score", {16'd0, score}, 32'd3);
`endif
    check("wrong_active_count", {27'd0, active_count}, 32'd15);

    // Reset in the middle of a MOVE
    bus.rd_slot = 4'd0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc(); cyc(); cyc();
    check("mid_move_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_active_count", {27'd0, active_count}, 32'd0);
    check("rstmid_score", {16'd0, score}, 32'd0);
    check("rstmid_miss_count", {24'd0, miss_count}, 32'd0);
    check("rstmid_rd_active", {31'd0, bus.rd_active}, 32'd0);
    cyc();
    check("rstmid_slot0_inactive", {31'd0, bus.rd_active}, 32'd0);
    check("rstmid_ready", {31'd0, bus.spawn_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
